// File: rtl/stat_bench_pkg.sv
`default_nettype none
// ============================================================================
// stat_bench_pkg : rotate and mixing-round helpers shared by stat_seq_bench
// Rev 1.0 - initial release
// ============================================================================
package stat_bench_pkg;

   localparam int COUNT_W = 16;
   // Helpers work on a fixed container; datapaths up to this width are supported.
   localparam int MAX_W   = 64;

   function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                             input int unsigned      n,
                                             input int unsigned      w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] vm;
      int unsigned      s;
      mask = {MAX_W{1'b1}} >> (MAX_W - w);
      vm   = v & mask;
      s    = n % w;
      return ((vm << s) | (vm >> (w - s))) & mask;
   endfunction

   function automatic logic [MAX_W-1:0] mix_round(input logic [MAX_W-1:0] x,
                                                  input int unsigned      k,
                                                  input logic [MAX_W-1:0] seed,
                                                  input int unsigned      w);
      return rotl(x, 1, w) ^ (x & rotl(x, 3, w)) ^ rotl(seed, k, w);
   endfunction

endpackage : stat_bench_pkg
`default_nettype wire

// File: rtl/stat_mix_stage.sv
`default_nettype none
// ============================================================================
// stat_mix_stage : one registered mixing round with valid/ready handshake
// Rev 1.0 - initial release
// ============================================================================
module stat_mix_stage
   import stat_bench_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter int               K     = 0,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(64'hA5A5_A5A5_A5A5_A5A5)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [MAX_W-1:0] mix_full;

   assign mix_full = mix_round(MAX_W'(up_data), K, MAX_W'(SEED), WIDTH);

   if (WIDTH < MAX_W) begin : g_pad
      logic unused_hi;
      assign unused_hi = |mix_full[MAX_W-1:WIDTH];
   end

   // An empty stage accepts regardless of downstream, so bubbles collapse.
   assign ready = ~valid_q | dn_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (ready) begin
         valid_d = up_valid;
         if (up_valid) begin
            data_d = mix_full[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule : stat_mix_stage
`default_nettype wire

// File: rtl/stat_seq_bench.sv
`default_nettype none
// ============================================================================
// stat_seq_bench : pipelined mixing benchmark with signature and word counter
// Rev 1.0 - initial release
// ============================================================================
module stat_seq_bench
   import stat_bench_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter int               STAGES = 3,
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(64'hA5A5_A5A5_A5A5_A5A5)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [WIDTH-1:0]   sig,
   output logic [COUNT_W-1:0] out_count
);

   logic [WIDTH-1:0]   d [STAGES];
   logic [STAGES-1:0]  v;
   logic [STAGES:0]    r;
   logic [WIDTH-1:0]   sig_q, sig_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               xfer;

   assign r[STAGES] = out_ready;
   assign in_ready  = r[0] & ~clear;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (k == 0) begin : g_head
         assign src_valid = in_valid & in_ready;
         assign src_data  = in_data;
      end else begin : g_body
         assign src_valid = v[k-1];
         assign src_data  = d[k-1];
      end

      stat_mix_stage #(
         .WIDTH (WIDTH),
         .K     (k),
         .SEED  (SEED)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (clear),
         .up_valid (src_valid),
         .up_data  (src_data),
         .dn_ready (r[k+1]),
         .ready    (r[k]),
         .valid    (v[k]),
         .data     (d[k])
      );
   end

   assign out_valid = v[STAGES-1];
   assign out_data  = d[STAGES-1];
   assign xfer      = out_valid & out_ready;

   // A word leaving on a clear edge is still consumed, just never folded.
   always_comb begin
      sig_d   = sig_q;
      count_d = count_q;
      if (clear) begin
         sig_d   = '0;
         count_d = '0;
      end else if (xfer) begin
         sig_d   = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ out_data;
         count_d = count_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q   <= '0;
         count_q <= '0;
      end else begin
         sig_q   <= sig_d;
         count_q <= count_d;
      end
   end

   assign sig       = sig_q;
   assign out_count = count_q;

endmodule : stat_seq_bench
`default_nettype wire

// File: tb/tb_stat_seq_bench.sv
`default_nettype none
// ============================================================================
// tb_stat_seq_bench : directed and randomised checks for stat_seq_bench
// Rev 1.0 - initial release
// ============================================================================
module tb_stat_seq_bench;

   localparam int          W    = 32;
   localparam int          ST   = 3;
   localparam logic [31:0] SEED = 32'hA5A5_A5A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-configuration DUT
   logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data, sig;
   logic [15:0] out_count;

   // 8-bit single-stage DUT
   logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0]  a_in_data, a_out_data, a_sig;
   logic [15:0] a_out_count;

   stat_seq_bench u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sig(sig), .out_count(out_count)
   );

   stat_seq_bench #(.WIDTH(8), .STAGES(1), .SEED(8'hA5)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .clear(a_clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .sig(a_sig), .out_count(a_out_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      int s;
      s = n % 32;
      if (s == 0) return x;
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] x);
      logic [31:0] y;
      y = x;
      for (int k = 0; k < ST; k++) y = rl(y, 1) ^ (y & rl(y, 3)) ^ rl(SEED, k);
      return y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected words in flight plus the reference signature/count.
   logic [31:0] q[$];
   logic [31:0] m_sig;
   logic [15:0] m_cnt;
   logic [31:0] mon_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_sig = '0;
         m_cnt = '0;
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000_0000);
            end else begin
               mon_exp = q.pop_front();
               chk("stream_data", 64'(out_data), 64'(mon_exp));
            end
            chk("stream_sig", 64'(sig), 64'(m_sig));
            chk("stream_count", 64'(out_count), 64'(m_cnt));
            if (!clear) begin
               m_sig = rl(m_sig, 1) ^ out_data;
               m_cnt = m_cnt + 16'd1;
            end
         end
         if (clear) begin
            q.delete();
            m_sig = '0;
            m_cnt = '0;
         end else if (in_valid && in_ready) begin
            q.push_back(ref_word(in_data));
         end
      end
   end

   task automatic drain(input string name);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((out_valid || q.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      chk(name, 64'(q.size()), 64'd0);
   endtask

   typedef struct {
      logic [7:0]  din;
      logic [7:0]  dout;
      logic [7:0]  sig;
      logic [15:0] cnt;
   } vec8_t;

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
   } vec32_t;

   vec8_t  t1[5];
   vec32_t t2[8];

   initial begin
      int          first_out, last_out, n_out, acc, sent, n;
      logic        take;
      logic [31:0] w;

      t1[0] = '{8'h01, 8'hA7, 8'hA7, 16'd1};
      t1[1] = '{8'hFF, 8'hA5, 8'hEA, 16'd2};
      t1[2] = '{8'h00, 8'hA5, 8'h70, 16'd3};
      t1[3] = '{8'h80, 8'hA4, 8'h44, 16'd4};
      t1[4] = '{8'h0F, 8'hB3, 8'h3B, 16'd5};

      t2[0].din = 32'h0000_0000;  t2[1].din = 32'h0000_0001;
      t2[2].din = 32'hFFFF_FFFF;  t2[3].din = 32'h8000_0000;
      t2[4].din = 32'h1234_5678;  t2[5].din = 32'hDEAD_BEEF;
      t2[6].din = 32'hA5A5_A5A5;  t2[7].din = 32'h5A5A_5A5A;
      for (int i = 0; i < 8; i++) t2[i].dout = ref_word(t2[i].din);

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      a_clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;

      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_sig", 64'(sig), 64'd0);
      chk("rst_count", 64'(out_count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 8-bit, single stage: hand-computed words and signatures
      for (int i = 0; i < 5; i++) begin
         a_in_data  = t1[i].din;
         a_in_valid = 1'b1;
         tick();
         a_in_valid = 1'b0;
         chk("t1_out_valid", 64'(a_out_valid), 64'd1);
         chk("t1_out_data", 64'(a_out_data), 64'(t1[i].dout));
         tick();
         chk("t1_sig", 64'(a_sig), 64'(t1[i].sig));
         chk("t1_count", 64'(a_out_count), 64'(t1[i].cnt));
         chk("t1_idle", 64'(a_out_valid), 64'd0);
      end

      // Back-to-back stream: latency, contiguity and data
      out_ready = 1'b1;
      first_out = -1; last_out = -1; n_out = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 8) begin
            in_valid = 1'b1;
            in_data  = t2[i].din;
            chk("t2_in_ready", 64'(in_ready), 64'd1);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            if (first_out < 0) first_out = i;
            last_out = i;
            if (n_out < 8) chk("t2_data", 64'(out_data), 64'(t2[n_out].dout));
            n_out++;
         end
      end
      chk("t2_latency", 64'(first_out), 64'(ST - 1));
      chk("t2_last", 64'(last_out), 64'(ST - 1 + 7));
      chk("t2_outputs", 64'(n_out), 64'd8);
      chk("t2_count", 64'(out_count), 64'd8);

      // Stall: pipeline fills with STAGES words then back-pressures
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = t2[acc].din;
         #1;
         take = in_ready;
         tick();
         if (take) acc++;
      end
      chk("t3_accepts", 64'(acc), 64'(ST));
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      chk("t3_head", 64'(out_data), 64'(t2[0].dout));
      tick();
      chk("t3_hold", 64'(out_data), 64'(t2[0].dout));
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      drain("t3_drain");
      chk("t3_count", 64'(out_count), 64'd11);

      // Random valid/ready traffic, checked by the scoreboard
      sent = 0;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         #1;
         if (in_valid && in_ready) sent++;
         tick();
      end
      drain("t4_drain");
      chk("t4_sent", 64'(sent), 64'd1000);
      chk("t4_count", 64'(out_count), 64'd1011);

      // Clear with a full pipeline while a word is leaving
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_data = 32'h0000_1000 + 32'(c);
         tick();
      end
      chk("t5_full", 64'(in_ready), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clear     = 1'b1;
      #1;
      chk("t5_clear_in_ready", 64'(in_ready), 64'd0);
      tick();
      clear = 1'b0;
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_sig", 64'(sig), 64'd0);
      chk("t5_count", 64'(out_count), 64'd0);
      w = 32'h0BAD_CAFE;
      in_valid = 1'b1;
      in_data  = w;
      tick();
      drain("t5_drain");
      chk("t5_post_sig", 64'(sig), 64'(ref_word(w)));
      chk("t5_post_count", 64'(out_count), 64'd1);

      // Asynchronous reset in the middle of a cycle during traffic
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_data = $urandom;
         tick();
      end
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_out_data", 64'(out_data), 64'd0);
      chk("t6_sig", 64'(sig), 64'd0);
      chk("t6_count", 64'(out_count), 64'd0);
      #5;
      rst_n = 1'b1;
      tick();
      w = 32'hCAFE_F00D;
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk("t6_word", 64'(out_data), 64'(ref_word(w)));
      tick();
      chk("t6_post_sig", 64'(sig), 64'(ref_word(w)));
      chk("t6_post_count", 64'(out_count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_stat_seq_bench
`default_nettype wire

// File: doc/stat_seq_bench.md
# stat_seq_bench

Parametrised sequential synthetic benchmark, the pipelined successor to the flat 32-in/32-out combinational Stat netlists. It pushes WIDTH-bit words through STAGES registered rounds of a fixed, fully specified mixing function under valid/ready flow control. A MISR-style signature and an output counter fold every delivered word. It serves as a deterministic sequential target for the circuit tools: locking, unrolling and equivalence flows.

## Interface
Parameters:
- WIDTH, 32, datapath width; even, ≥ 8
- STAGES, 3, number of registered mixing rounds; 1..8
- SEED, WIDTH'hA5…A5 (byte A5 replicated), round-constant seed

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- clear  in  1  synchronous flush of pipeline, signature and counter
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the input word this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts the output word
- out_data  out  WIDTH  mixed word
- sig  out  WIDTH  running signature
- out_count  out  16  number of words folded into sig, wraps

## Operation
- rotl(v,n): rotate left by n mod WIDTH.
- Round k (k = 0..STAGES-1): y = rotl(x,1) ^ (x & rotl(x,3)) ^ C_k, where C_k = rotl(SEED,k).
- Stage k holds a data register d[k] and valid bit v[k]. Stage 0 loads from in_data. out_data = d[STAGES-1]; out_valid = v[STAGES-1].
- Ready chain: r[STAGES] = out_ready; r[k] = !v[k] | r[k+1]. in_ready = r[0] & !clear.
- Stage k loads when r[k] is high:
  - Load source: in_data for k = 0, otherwise round k-1 output.
  - v[k] ← upstream valid.
  - Stage 0's upstream valid is in_valid & in_ready.
- The data register loads only when the incoming valid is 1. It holds otherwise.
- Output transfer = out_valid & out_ready. On transfer, when clear is low:
  - sig ← rotl(sig,1) ^ out_data
  - out_count ← out_count + 1, mod 2^16
- clear high:
  - All v[k] ← 0, sig ← 0, out_count ← 0. clear has priority over every load and fold.
  - A transfer at the same edge is still consumed downstream but is not folded.
- No FSM beyond the per-stage valid bits. No words are dropped or duplicated under any out_ready pattern.

## Timing
- Reset (rst_n low, async): all v[k] = 0, all d[k] = 0, sig = 0, out_count = 0.
  - Hence out_valid = 0 and out_data = 0.
  - in_ready = 1 whenever clear is low.
- Latency: a word accepted at edge t appears with out_valid high after edge t+STAGES-1. It is visible in the cycle following that edge.
- Throughput: 1 word/cycle while out_ready is held high.
- Full pipeline with out_ready low: in_ready = 0. Data and valids hold unchanged.
- Bubbles collapse: a stage with v = 0 accepts even when downstream is stalled.
- in_ready is combinational from out_ready through the ready chain. There is no combinational path from in_data to any output.
- rst_n asserted mid-stream: in-flight words are lost and outputs return to reset values at once. Release is synchronised externally.

## Structure
- Package stat_bench_pkg:
  - function rotl
  - function mix_round(x, k, SEED)
  - localparam COUNT_W = 16
- Sub-module stat_mix_stage: one register stage holding d, v, and the ready term. It is generated STAGES times.
- The top holds the ready chain, the signature register and the counter.

## Test plan
- WIDTH=8, STAGES=1, SEED=8'hA5, out_ready=1; send 8'h01 then 8'hFF -> out_data 8'hA7 then 8'hA5; sig 8'hA7 then 8'hEA; out_count 1 then 2.
- Defaults; reset, send 8 consecutive words with out_ready=1 -> first out_valid exactly 3 cycles after first accept; 8 contiguous outputs matching the reference model; out_count = 8.
- Defaults; out_ready=0 with in_valid held -> in_ready drops after 3 accepts; data stable; raise out_ready -> all words drained in order, no loss or duplication.
- Random in_valid/out_ready (50%) for 1000 words -> out_data stream, sig and out_count match the model at every transfer.
- Pipeline full and clear pulsed with out_ready=1 -> next cycle out_valid=0, sig=0, out_count=0; the word transferred on the clear edge is not folded.
- rst_n pulsed low mid-cycle during traffic -> outputs reach reset values immediately, without waiting for a clock edge; the first post-reset word yields correct output and sig = that word's out_data.
